// File: rtl/button_clock_unit.sv
// button_clock_unit: free-running binary clock divider plus a debounced
// push-button conditioner. One divider tap paces button sampling; the block
// produces a clean level, single-cycle rise/fall pulses and a press-toggle.
// Every flop runs on clk; divider bits are only ever used as data/enables.
module button_clock_unit #(
  parameter int PWR_2   = 20,  // divider width, 2..32
  parameter int BTN_TAP = 16,  // divider bit pacing button sampling, < PWR_2
  parameter int DEB_N   = 3    // consecutive equal samples to change level, 2..8
) (
  input  logic             clk,
  input  logic             reset,   // asynchronous, active-low
  input  logic             i,       // raw button, asynchronous to clk
  output logic [PWR_2-1:0] sclks,
  output logic             tick,
  output logic             o,
  output logic             rise,
  output logic             fall,
  output logic             toggle
);

  // Debounced level tracked as a two-state machine; o is the state itself.
  typedef enum logic {
    LVL_LOW  = 1'b0,
    LVL_HIGH = 1'b1
  } lvl_state_t;

  logic [PWR_2-1:0] cnt_q, cnt_d;
  logic             sync1_q, sync2_q;
  logic [DEB_N-1:0] samp_q, samp_d;
  lvl_state_t       state_q, state_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             toggle_q, toggle_d;
  logic             tick_w;
  logic             all_ones, all_zeros;

  // ---------------------------------------------------------------------
  // Divider: plain wrap-around counter, every bit is a slow-clock tap.
  // ---------------------------------------------------------------------
  assign cnt_d = cnt_q + {{(PWR_2-1){1'b0}}, 1'b1};

  // Counter register, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Tick marks the first cycle of each high phase of the chosen tap, so it
  // is one cycle wide and spaced exactly 2^(BTN_TAP+1) cycles, even across wrap.
  generate
    if (BTN_TAP == 0) begin : g_tick_lsb
      assign tick_w = cnt_q[0];
    end else begin : g_tick_tap
      assign tick_w = cnt_q[BTN_TAP] & ~(|cnt_q[BTN_TAP-1:0]);
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Two-flop synchronizer for the asynchronous button input.
  // ---------------------------------------------------------------------
  // Synchronizer chain; only sync2_q is ever consumed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= i;
      sync2_q <= sync1_q;
    end
  end

  // ---------------------------------------------------------------------
  // Sample history: shift in the synchronized button only on tick.
  // ---------------------------------------------------------------------
  // Next sample window, including the sample taken on this edge.
  always_comb begin
    samp_d = samp_q;
    if (tick_w) samp_d = {samp_q[DEB_N-2:0], sync2_q};
  end

  assign all_ones  = &samp_d;
  assign all_zeros = ~(|samp_d);

  // Sample history register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) samp_q <= '0;
    else        samp_q <= samp_d;
  end

  // ---------------------------------------------------------------------
  // Level FSM: a unanimous window flips the level; mixed windows hold it.
  // Edge pulses and toggle are decided in the same process so they line up
  // with the level change.
  // ---------------------------------------------------------------------
  // Next-state, edge-pulse and toggle decode.
  always_comb begin
    state_d  = state_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    toggle_d = toggle_q;
    if (tick_w) begin
      case (state_q)
        LVL_LOW: begin
          if (all_ones) begin
            state_d  = LVL_HIGH;
            rise_d   = 1'b1;
            toggle_d = ~toggle_q;
          end
        end
        LVL_HIGH: begin
          if (all_zeros) begin
            state_d = LVL_LOW;
            fall_d  = 1'b1;
          end
        end
        default: state_d = LVL_LOW;
      endcase
    end
  end

  // Level state and registered pulse/toggle outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= LVL_LOW;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      toggle_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      toggle_q <= toggle_d;
    end
  end

  assign sclks  = cnt_q;
  assign tick   = tick_w;
  assign o      = (state_q == LVL_HIGH);
  assign rise   = rise_q;
  assign fall   = fall_q;
  assign toggle = toggle_q;

endmodule

// File: tb/tb_button_clock_unit.sv
// Directed self-checking bench for button_clock_unit with PWR_2=6,
// BTN_TAP=2, DEB_N=3. Edges are numbered from reset release; sampling
// edges are those with edge number = 5 mod 8.
module tb_button_clock_unit;

  localparam int PWR_2   = 6;
  localparam int BTN_TAP = 2;
  localparam int DEB_N   = 3;

  logic             clk;
  logic             reset;
  logic             i;
  logic [PWR_2-1:0] sclks;
  logic             tick;
  logic             o;
  logic             rise;
  logic             fall;
  logic             toggle;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  button_clock_unit #(
    .PWR_2  (PWR_2),
    .BTN_TAP(BTN_TAP),
    .DEB_N  (DEB_N)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .i     (i),
    .sclks (sclks),
    .tick  (tick),
    .o     (o),
    .rise  (rise),
    .fall  (fall),
    .toggle(toggle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s (edge %0d): observed=%0h expected=%0h", tag, edge_n, obs, exp);
    end
  endtask

  // Advance one edge, sample 1 time unit later, and check all outputs.
  task automatic step_check(input logic exp_o, input logic exp_rise,
                            input logic exp_fall, input logic exp_toggle);
    logic [31:0] exp_cnt;
    @(posedge clk);
    #1;
    edge_n++;
    exp_cnt = edge_n % 64;
    check("sclks",   {26'd0, sclks}, exp_cnt);
    check("sclks0",  sclks[0], exp_cnt[0]);
    check("sclks5",  sclks[5], exp_cnt[5]);
    check("tick",    tick, (exp_cnt % 8) == 4);
    check("o",       o, exp_o);
    check("rise",    rise, exp_rise);
    check("fall",    fall, exp_fall);
    check("toggle",  toggle, exp_toggle);
    $display("edge %0d: i=%0b sclks=%0d tick=%0b o=%0b rise=%0b fall=%0b toggle=%0b",
             edge_n, i, sclks, tick, o, rise, fall, toggle);
  endtask

  initial begin
    reset = 1'b0;
    i     = 1'b0;

    // Reset held across several edges: everything reads 0.
    repeat (3) @(posedge clk);
    #1;
    check("rst_sclks",  {26'd0, sclks}, 32'd0);
    check("rst_tick",   tick, 1'b0);
    check("rst_o",      o, 1'b0);
    check("rst_rise",   rise, 1'b0);
    check("rst_fall",   fall, 1'b0);
    check("rst_toggle", toggle, 1'b0);

    // Release reset with the button already held: clean press reported at edge 21.
    @(negedge clk);
    reset = 1'b1;
    i     = 1'b1;
    for (int e = 1; e <= 24; e++)
      step_check(e >= 21, e == 21, 1'b0, e >= 21);

    // Keep running across the counter wrap at edge 64 (tick at edge 68).
    for (int e = 25; e <= 72; e++)
      step_check(1'b1, 1'b0, 1'b0, 1'b1);

    // Release: first zero sample at edge 77, level drops at edge 93.
    i = 1'b0;
    for (int e = 73; e <= 100; e++)
      step_check(e < 93, 1'b0, e == 93, 1'b1);

    // 10-cycle glitch: never enough consecutive samples to change the level.
    i = 1'b1;
    for (int e = 101; e <= 110; e++)
      step_check(1'b0, 1'b0, 1'b0, 1'b1);
    i = 1'b0;
    for (int e = 111; e <= 140; e++)
      step_check(1'b0, 1'b0, 1'b0, 1'b1);

    // Second press: samples at 149, 157, 165 -> rise at 165, toggle returns to 0.
    i = 1'b1;
    for (int e = 141; e <= 170; e++)
      step_check(e >= 165, e == 165, 1'b0, e < 165);

    // Asynchronous reset mid-cycle while o=1: outputs clear before the next edge.
    #2;
    reset = 1'b0;
    #1;
    check("arst_sclks",  {26'd0, sclks}, 32'd0);
    check("arst_o",      o, 1'b0);
    check("arst_toggle", toggle, 1'b0);
    check("arst_rise",   rise, 1'b0);
    check("arst_fall",   fall, 1'b0);
    check("arst_tick",   tick, 1'b0);
    $display("async reset: sclks=%0d o=%0b toggle=%0b", sclks, o, toggle);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
